// File: rtl/alu_multicycle.sv
// Multicycle ALU: registered result, valid/ready handshake, shift-add multiplier.
// Define ALU_MULTICYCLE_DIV_EN to build the restoring divider for DIVU/REMU.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_REM = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;       // multiplicand (shifts left) or divisor
  logic [WIDTH-1:0] r_b;       // multiplier (shifts right)
  logic [WIDTH-1:0] r_acc;     // product accumulator or partial remainder
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_long;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_final;

  function automatic logic [WIDTH-1:0] f_single(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_SUB:  return a - b;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign w_single  = f_single(ALU_Control, A, B);
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

`ifdef ALU_MULTICYCLE_DIV_EN
  localparam logic [1:0] K_MUL = 2'd0;
  localparam logic [1:0] K_DIV = 2'd1;
  localparam logic [1:0] K_REM = 2'd2;

  logic [1:0]       r_kind;
  logic [WIDTH-1:0] r_q;       // dividend shifting out, quotient shifting in
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_long    = (ALU_Control == OP_MUL) || (ALU_Control == OP_DIV) ||
                     (ALU_Control == OP_REM);
  // A zero divisor always fits, giving all-ones quotient and remainder == A.
  assign w_shift   = {r_acc, r_q[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_a};
  assign w_fit     = ~w_diff[WIDTH];
  assign w_rem_nxt = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_q[WIDTH-2:0], w_fit};

  always_comb begin
    case (r_kind)
      K_DIV:   w_final = w_quo_nxt;
      K_REM:   w_final = w_rem_nxt;
      default: w_final = w_mul_acc;
    endcase
  end
`else
  assign w_long  = (ALU_Control == OP_MUL);
  assign w_final = w_mul_acc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_long ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch on transfer, iterate in BUSY, write result on last step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
`ifdef ALU_MULTICYCLE_DIV_EN
      r_kind   <= K_MUL;
      r_q      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_long) begin
              r_a   <= (ALU_Control == OP_MUL) ? A : B;
              r_b   <= B;
              r_acc <= '0;
              r_cnt <= CNT_W'(WIDTH);
`ifdef ALU_MULTICYCLE_DIV_EN
              r_q    <= A;
              r_kind <= (ALU_Control == OP_DIV) ? K_DIV :
                        (ALU_Control == OP_REM) ? K_REM : K_MUL;
`endif
            end else begin
              r_result <= w_single;
              r_zero   <= (w_single == '0);
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
`ifdef ALU_MULTICYCLE_DIV_EN
          if (r_kind == K_MUL) begin
            r_acc <= w_mul_acc;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end else begin
            r_acc <= w_rem_nxt;
            r_q   <= w_quo_nxt;
          end
`else
          r_acc <= w_mul_acc;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
`endif
          if (r_cnt == CNT_W'(1)) begin
            r_result <= w_final;
            r_zero   <= (w_final == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign ALU_Result = r_result;
  assign Zero       = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, corner-case
// sequences, and random operations against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_Control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Result;
  logic         Zero;

  int checks   = 0;
  int failures = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Control(ALU_Control), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_Result(ALU_Result), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op,
                              logic [W-1:0] exp, int lat);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  function automatic logic [W-1:0] ref_result(logic [W-1:0] a, logic [W-1:0] b,
                                              logic [3:0] op);
    longint unsigned ua = a;
    longint unsigned ub = b;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return W'(ua + ub);
      4'b0011: return a ^ b;
      4'b0110: return W'(ua - ub);
      4'b0111: return (ua < ub) ? 1 : 0;
      4'b1100: return ~(a | b);
      4'b1000: return W'(ua * ub);
`ifdef ALU_MULTICYCLE_DIV_EN
      4'b1001: return (ub == 0) ? {W{1'b1}} : W'(ua / ub);
      4'b1010: return (ub == 0) ? a : W'(ua % ub);
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(logic [3:0] op);
    if (op == 4'b1000) return W + 1;
`ifdef ALU_MULTICYCLE_DIV_EN
    if (op == 4'b1001 || op == 4'b1010) return W + 1;
`endif
    return 1;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        input logic [W-1:0] exp, input int exp_lat, input string nm);
    int   lat;
    logic busy_bad;
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, W'(in_ready), W'(1));
    A = a; B = b; ALU_Control = op; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALU_Control = 4'($urandom);
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, W'(lat), W'(exp_lat));
    chk({nm, "_in_ready_busy"}, W'(busy_bad), W'(0));
    chk({nm, "_in_ready_done"}, W'(in_ready), W'(0));
    chk({nm, "_result"}, ALU_Result, exp);
    chk({nm, "_zero"}, W'(Zero), W'(exp == '0));
    if (out_ready) begin
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, W'(out_valid), W'(0));
      chk({nm, "_back_idle"}, W'(in_ready), W'(1));
    end
  endtask

  logic [3:0] ops [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd8,
                           4'd9, 4'd10, 4'd4, 4'd5, 4'd11, 4'd13, 4'd14, 4'd15};

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    logic         seen;

    tbl.push_back(mk(32'd5, 32'd7, 4'b0110, 32'hFFFF_FFFE, 1));
    tbl.push_back(mk(32'd5, 32'd7, 4'b0111, 32'd1, 1));
    tbl.push_back(mk(32'd7, 32'd7, 4'b0110, 32'd0, 1));
    tbl.push_back(mk(32'd7, 32'd5, 4'b0111, 32'd0, 1));
    tbl.push_back(mk(32'hF0F0, 32'hFF00, 4'b0000, 32'hF000, 1));
    tbl.push_back(mk(32'hF0F0, 32'hFF00, 4'b0001, 32'hFFF0, 1));
    tbl.push_back(mk(32'hF0F0, 32'hFF00, 4'b0011, 32'h0FF0, 1));
    tbl.push_back(mk(32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1));
    tbl.push_back(mk(32'd0, 32'd0, 4'b1100, 32'hFFFF_FFFF, 1));
    tbl.push_back(mk(32'd9, 32'd3, 4'b0100, 32'd0, 1));
    tbl.push_back(mk(32'd9, 32'd3, 4'b1111, 32'd0, 1));
    tbl.push_back(mk(32'h0001_0000, 32'h0001_0000, 4'b1000, 32'd0, 33));
    tbl.push_back(mk(32'd1234, 32'd5678, 4'b1000, 32'd7006652, 33));
    tbl.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 32'd1, 33));
`ifdef ALU_MULTICYCLE_DIV_EN
    tbl.push_back(mk(32'd100, 32'd7, 4'b1001, 32'd14, 33));
    tbl.push_back(mk(32'd100, 32'd7, 4'b1010, 32'd2, 33));
    tbl.push_back(mk(32'd5, 32'd0, 4'b1001, 32'hFFFF_FFFF, 33));
    tbl.push_back(mk(32'd9, 32'd0, 4'b1010, 32'd9, 33));
    tbl.push_back(mk(32'hFFFF_FFFF, 32'd1, 4'b1001, 32'hFFFF_FFFF, 33));
`else
    tbl.push_back(mk(32'd100, 32'd7, 4'b1001, 32'd0, 1));
    tbl.push_back(mk(32'd100, 32'd7, 4'b1010, 32'd0, 1));
    tbl.push_back(mk(32'd5, 32'd0, 4'b1001, 32'd0, 1));
    tbl.push_back(mk(32'd9, 32'd0, 4'b1010, 32'd0, 1));
`endif

    // Reset with in_valid high: reset values, no transfer
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    A = 32'd3; B = 32'd4; ALU_Control = 4'b0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", ALU_Result, '0);
    chk("rst_zero", W'(Zero), W'(1));
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_no_transfer", W'(out_valid), W'(0));

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));
    end

    // Back-pressure: result held, new operands ignored
    out_ready = 1'b0;
    run_op(32'd3, 32'd4, 4'b0010, 32'd7, 1, "bp_add");
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; A = 32'd100; B = 32'd200; ALU_Control = 4'b0010;
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), W'(out_valid), W'(1));
      chk($sformatf("bp_hold_result%0d", k), ALU_Result, 32'd7);
      chk($sformatf("bp_hold_ready%0d", k), W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", W'(out_valid), W'(0));
    chk("bp_release_ready", W'(in_ready), W'(1));
    chk("bp_release_result", ALU_Result, 32'd7);

    // Reset during MUL aborts it
    @(negedge clk);
    A = 32'd1234; B = 32'd5678; ALU_Control = 4'b1000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_result", ALU_Result, '0);
    chk("abort_zero", W'(Zero), W'(1));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_stale_valid", W'(seen), W'(0));
    run_op(32'd1, 32'd1, 4'b0010, 32'd2, 1, "abort_fresh_add");

    // Random operations against the reference model
    for (int n = 0; n < 120; n++) begin
      rop = ops[$urandom_range(15, 0)];
      ra  = ($urandom_range(3, 0) == 0) ? W'($urandom_range(20, 0)) : W'($urandom);
      case ($urandom_range(5, 0))
        0:       rb = '0;
        1:       rb = W'($urandom_range(20, 1));
        2:       rb = ra;
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb, rop, ref_result(ra, rb, rop), ref_lat(rop), $sformatf("rnd%0d_op%0d", n, rop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
